// File: rtl/operand2_seq_shifter.sv
// rtl/operand2_seq_shifter.sv - multi-cycle register-specified operand-2 shifter, one bit per cycle
module operand2_seq_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       sh,
    input  logic [7:0]       amount,
    input  logic [WIDTH-1:0] src,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;
    localparam logic [7:0] MAX_STEPS = 8'(WIDTH + 1);
    localparam logic [7:0] ROR_MASK  = 8'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] res_q, res_nxt;
    logic             c_q, c_nxt;
    logic [1:0]       sh_q, sh_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [7:0]       steps;
    logic [CW-1:0]    n;

    // WIDTH+1 steps already flush everything out, so larger amounts are clamped
    assign steps = (sh == SH_ROR) ? (amount & ROR_MASK)
                 : ((amount > MAX_STEPS) ? MAX_STEPS : amount);
    assign n = CW'(steps);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            res_q <= '0;
            c_q   <= 1'b0;
            sh_q  <= SH_LSL;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            res_q <= res_nxt;
            c_q   <= c_nxt;
            sh_q  <= sh_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        res_nxt   = res_q;
        c_nxt     = c_q;
        sh_nxt    = sh_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    res_nxt = src;
                    sh_nxt  = sh;
                    c_nxt   = carry_in;
                    cnt_nxt = n;
                    // ROR by a nonzero multiple of WIDTH: no movement, carry is the MSB
                    if (sh == SH_ROR && amount != 8'd0 && n == '0)
                        c_nxt = src[WIDTH-1];
                    state_nxt = (n == '0) ? DONE : SHIFT;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                case (sh_q)
                    SH_LSL: begin
                        c_nxt   = res_q[WIDTH-1];
                        res_nxt = {res_q[WIDTH-2:0], 1'b0};
                    end
                    SH_LSR: begin
                        c_nxt   = res_q[0];
                        res_nxt = {1'b0, res_q[WIDTH-1:1]};
                    end
                    SH_ASR: begin
                        c_nxt   = res_q[0];
                        res_nxt = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                    end
                    default: begin
                        c_nxt   = res_q[0];
                        res_nxt = {res_q[0], res_q[WIDTH-1:1]};
                    end
                endcase
                cnt_nxt = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign result    = res_q;
    assign carry_out = c_q;
    assign done      = (state == DONE);
    assign busy      = (state == SHIFT);
endmodule
